// File: rtl/clock_group_pkg.sv
// Shared types and sizing for the clock-group reset sequencer.
package clock_group_pkg;

   localparam int unsigned CNT_W               = 8;
   localparam int unsigned DEFAULT_N_MEMBERS   = 4;
   localparam int unsigned DEFAULT_HOLD_CYCLES = 16;
   localparam int unsigned DEFAULT_GAP_CYCLES  = 4;

   typedef enum logic [2:0] {
      StIdle,
      StHold,
      StGate,
      StRelease,
      StUngate,
      StGap,
      StDone
   } state_e;

endpackage

// File: rtl/clock_group_delay_counter.sv
// Up-counter timing both the reset-hold window and the inter-release gap.
// tc is high on the last cycle of a window of (limit + 1) cycles.
module clock_group_delay_counter
   import clock_group_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             enable,
   input  logic [CNT_W-1:0] limit,
   output logic             tc
);

   logic [CNT_W-1:0] count_q, count_d;

   assign tc = (count_q == limit);

   // Saturates at the limit so the count can never wrap.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = '0;
      end else if (enable && !tc) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/clock_group_reset_sequencer.sv
// Holds selected clock-group members in reset, then releases them one at a time in
// ascending index order, gating each member's clock around its reset release.
module clock_group_reset_sequencer
   import clock_group_pkg::*;
#(
   parameter int unsigned N_MEMBERS   = DEFAULT_N_MEMBERS,
   parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
   parameter int unsigned GAP_CYCLES  = DEFAULT_GAP_CYCLES
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 io_req_valid,
   output logic                 io_req_ready,
   input  logic [N_MEMBERS-1:0] io_req_mask,
   output logic [N_MEMBERS-1:0] io_member_reset,
   output logic [N_MEMBERS-1:0] io_member_clken,
   output logic                 io_busy,
   output logic                 io_done
);

   localparam int unsigned SEL_W = (N_MEMBERS > 1) ? $clog2(N_MEMBERS) : 1;
   localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LIMIT  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

   state_e                 state_q, state_d;
   logic [N_MEMBERS-1:0]   pending_q, pending_d;
   logic [N_MEMBERS-1:0]   member_reset_q, member_reset_d;
   logic [N_MEMBERS-1:0]   member_clken_q, member_clken_d;
   logic [SEL_W-1:0]       sel;
   logic                   cnt_load, cnt_en, cnt_tc;
   logic [CNT_W-1:0]       cnt_limit;

   // Lowest-index pending member; stable through GATE/RELEASE because the
   // pending bit is only cleared on the way into UNGATE.
   always_comb begin
      sel = '0;
      for (int i = int'(N_MEMBERS) - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            sel = SEL_W'(i);
         end
      end
   end

   assign cnt_limit = (state_q == StGap) ? GAP_LIMIT : HOLD_LIMIT;

   clock_group_delay_counter u_delay (
      .clock  (clock),
      .reset  (reset),
      .load   (cnt_load),
      .enable (cnt_en),
      .limit  (cnt_limit),
      .tc     (cnt_tc)
   );

   always_comb begin
      state_d        = state_q;
      pending_d      = pending_q;
      member_reset_d = member_reset_q;
      member_clken_d = member_clken_q;
      cnt_load       = 1'b0;
      cnt_en         = 1'b0;
      case (state_q)
         StIdle: begin
            if (io_req_valid) begin
               pending_d = io_req_mask;
               cnt_load  = 1'b1;
               if (io_req_mask == '0) begin
                  state_d = StDone;
               end else begin
                  member_reset_d = member_reset_q | io_req_mask;
                  member_clken_d = member_clken_q | io_req_mask;
                  state_d        = StHold;
               end
            end
         end
         StHold: begin
            cnt_en = 1'b1;
            if (cnt_tc) begin
               member_clken_d[sel] = 1'b0;
               state_d             = StGate;
            end
         end
         StGate: begin
            member_reset_d[sel] = 1'b0;
            state_d             = StRelease;
         end
         StRelease: begin
            member_clken_d[sel] = 1'b1;
            pending_d[sel]      = 1'b0;
            state_d             = StUngate;
         end
         StUngate: begin
            if (pending_q == '0) begin
               state_d = StDone;
            end else if (GAP_CYCLES == 0) begin
               member_clken_d[sel] = 1'b0;
               state_d             = StGate;
            end else begin
               cnt_load = 1'b1;
               state_d  = StGap;
            end
         end
         StGap: begin
            cnt_en = 1'b1;
            if (cnt_tc) begin
               member_clken_d[sel] = 1'b0;
               state_d             = StGate;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Reset lands in HOLD with everything pending: a power-on sequence of all members.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= StHold;
         pending_q      <= '1;
         member_reset_q <= '1;
         member_clken_q <= '1;
      end else begin
         state_q        <= state_d;
         pending_q      <= pending_d;
         member_reset_q <= member_reset_d;
         member_clken_q <= member_clken_d;
      end
   end

   assign io_member_reset = member_reset_q;
   assign io_member_clken = member_clken_q;
   assign io_req_ready    = (state_q == StIdle);
   assign io_busy         = (state_q != StIdle);
   assign io_done         = (state_q == StDone);

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// Bench for clock_group_reset_sequencer: two instances (gap 4 and gap 0) checked every
// cycle against a schedule computed from hold/gap arithmetic.
module tb_clock_group_reset_sequencer;

   localparam int N    = 4;
   localparam int HOLD = 16;

   typedef struct packed {
      logic [3:0] rst;
      logic [3:0] clk;
      logic       busy;
      logic       ready;
      logic       done;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst_r   [2];
   logic       valid_r [2];
   logic [3:0] mask_r  [2];
   logic [3:0] mrst    [2];
   logic [3:0] mclk    [2];
   logic       ready_o [2];
   logic       busy_o  [2];
   logic       done_o  [2];
   logic [3:0] cur_rst [2];
   logic [3:0] cur_clk [2];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   clock_group_reset_sequencer #(
      .N_MEMBERS   (4),
      .HOLD_CYCLES (16),
      .GAP_CYCLES  (4)
   ) dut0 (
      .clock           (clk),
      .reset           (rst_r[0]),
      .io_req_valid    (valid_r[0]),
      .io_req_ready    (ready_o[0]),
      .io_req_mask     (mask_r[0]),
      .io_member_reset (mrst[0]),
      .io_member_clken (mclk[0]),
      .io_busy         (busy_o[0]),
      .io_done         (done_o[0])
   );

   clock_group_reset_sequencer #(
      .N_MEMBERS   (4),
      .HOLD_CYCLES (16),
      .GAP_CYCLES  (0)
   ) dut1 (
      .clock           (clk),
      .reset           (rst_r[1]),
      .io_req_valid    (valid_r[1]),
      .io_req_ready    (ready_o[1]),
      .io_req_mask     (mask_r[1]),
      .io_member_reset (mrst[1]),
      .io_member_clken (mclk[1]),
      .io_busy         (busy_o[1]),
      .io_done         (done_o[1])
   );

   function automatic int gap_of(input int inst);
      return (inst == 0) ? 4 : 0;
   endfunction

   function automatic int done_cycle(input int inst, input logic [3:0] mask);
      int k;
      k = $countones(mask);
      if (k == 0) return 1;
      return HOLD + 3 * k + gap_of(inst) * (k - 1) + 1;
   endfunction

   // Expected outputs c cycles after the accepting edge.
   function automatic obs_t model(input int inst, input logic [3:0] mask,
                                  input logic [3:0] s_rst, input logic [3:0] s_clk,
                                  input int c);
      obs_t e;
      int   p, g, dc;
      dc      = done_cycle(inst, mask);
      e.rst   = s_rst;
      e.clk   = s_clk;
      e.done  = (c == dc);
      e.busy  = (c <= dc);
      e.ready = (c > dc);
      p = 0;
      for (int i = 0; i < N; i++) begin
         if (mask[i]) begin
            g        = HOLD + 1 + p * (3 + gap_of(inst));
            e.rst[i] = (c <= g) ? 1'b1 : 1'b0;
            e.clk[i] = (c == g || c == g + 1) ? 1'b0 : 1'b1;
            p++;
         end
      end
      return e;
   endfunction

   function automatic obs_t observe(input int inst);
      obs_t o;
      o.rst   = mrst[inst];
      o.clk   = mclk[inst];
      o.busy  = busy_o[inst];
      o.ready = ready_o[inst];
      o.done  = done_o[inst];
      return o;
   endfunction

   // Called at the sampling point of cycle 1; returns at the sampling point of the first idle cycle.
   task automatic run_checks(input int inst, input logic [3:0] mask, input int abort_at,
                             input bit busy_req, input logic [3:0] next_mask);
      obs_t e, o;
      int   last;
      last = done_cycle(inst, mask) + 1;
      for (int c = 1; c <= last; c++) begin
         if (busy_req && c == 3) begin
            valid_r[inst] = 1'b1;
            mask_r[inst]  = next_mask;
         end
         e = model(inst, mask, cur_rst[inst], cur_clk[inst], c);
         o = observe(inst);
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL seq inst%0d mask=%b cycle %0d: got rst/clken/busy/ready/done=%b required %b",
                     inst, mask, c, o, e);
         end
         if (c == abort_at) begin
            rst_r[inst] = 1'b1;
            return;
         end
         if (c < last) begin
            @(posedge clk);
            #1;
         end
      end
      cur_rst[inst] = cur_rst[inst] & ~mask;
      cur_clk[inst] = cur_clk[inst] | mask;
   endtask

   task automatic request(input int inst, input logic [3:0] mask, input bit pre);
      if (!pre) begin
         checks++;
         if (ready_o[inst] !== 1'b1) begin
            failures++;
            $display("FAIL ready_before_req inst%0d: got %b required 1", inst, ready_o[inst]);
         end
         valid_r[inst] = 1'b1;
         mask_r[inst]  = mask;
      end
      @(posedge clk);
      #1;
      valid_r[inst] = 1'b0;
   endtask

   task automatic power_on(input int inst);
      obs_t o;
      rst_r[inst]   = 1'b1;
      valid_r[inst] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         o = observe(inst);
         checks++;
         if (o !== {4'hF, 4'hF, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL in_reset inst%0d edge %0d: got %b required %b", inst, i, o,
                     {4'hF, 4'hF, 1'b1, 1'b0, 1'b0});
         end
      end
      rst_r[inst]   = 1'b0;
      cur_rst[inst] = 4'hF;
      cur_clk[inst] = 4'hF;
      run_checks(inst, 4'hF, 0, 1'b0, 4'h0);
   endtask

   task automatic test_reset();
      power_on(0);
      power_on(1);
   endtask

   task automatic test_single_member();
      request(0, 4'b0100, 1'b0);
      run_checks(0, 4'b0100, 0, 1'b0, 4'h0);
   endtask

   task automatic test_zero_mask();
      request(0, 4'b0000, 1'b0);
      run_checks(0, 4'b0000, 0, 1'b0, 4'h0);
      request(1, 4'b0000, 1'b0);
      run_checks(1, 4'b0000, 0, 1'b0, 4'h0);
   endtask

   task automatic test_busy_request();
      request(0, 4'b1001, 1'b0);
      run_checks(0, 4'b1001, 0, 1'b1, 4'b0001);
      request(0, 4'b0001, 1'b1);
      run_checks(0, 4'b0001, 0, 1'b0, 4'h0);
   endtask

   task automatic test_gap_zero();
      request(1, 4'b1010, 1'b0);
      run_checks(1, 4'b1010, 0, 1'b0, 4'h0);
   endtask

   task automatic test_random();
      int         inst;
      logic [3:0] m;
      for (int n = 0; n < 8; n++) begin
         inst = int'($urandom_range(0, 1));
         m    = 4'($urandom_range(0, 15));
         request(inst, m, 1'b0);
         run_checks(inst, m, 0, 1'b0, 4'h0);
      end
   endtask

   // Reset lands in the gap after member 1 of a full sequence has been released.
   task automatic test_abort();
      request(0, 4'hF, 1'b0);
      run_checks(0, 4'hF, 28, 1'b0, 4'h0);
      power_on(0);
   endtask

   initial begin
      rst_r[0]   = 1'b1;
      rst_r[1]   = 1'b1;
      valid_r[0] = 1'b0;
      valid_r[1] = 1'b0;
      mask_r[0]  = 4'h0;
      mask_r[1]  = 4'h0;
      cur_rst[0] = 4'hF;
      cur_rst[1] = 4'hF;
      cur_clk[0] = 4'hF;
      cur_clk[1] = 4'hF;
      test_reset();
      test_single_member();
      test_zero_mask();
      test_busy_request();
      test_gap_zero();
      test_random();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
